// File: rtl/score_stats_if.sv
// Bus between the reaction counter / display mux and the score_stats engine.
// The master side drives scores and the display select; the slave side returns statistics.
interface score_stats_if;
    logic        score_valid;
    logic [11:0] score_bcd;
    logic        clear_best;
    logic [1:0]  sel;
    logic [11:0] disp_bcd;
    logic [11:0] last_bcd;
    logic [11:0] best_bcd;
    logic [11:0] avg_bcd;
    logic [3:0]  rounds;
    logic        busy;
    logic        err;

    modport master (
        output score_valid, score_bcd, clear_best, sel,
        input  disp_bcd, last_bcd, best_bcd, avg_bcd, rounds, busy, err
    );

    modport slave (
        input  score_valid, score_bcd, clear_best, sel,
        output disp_bcd, last_bcd, best_bcd, avg_bcd, rounds, busy, err
    );
endinterface

// File: rtl/score_stats.sv
// Reaction-round statistics: last/best score, ring buffer of recent scores and their
// BCD average, computed by a serial restoring divider followed by double-dabble.
module score_stats #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [11:0] BEST_INIT = 12'h999
) (
    input logic          board_clk,
    input logic          reset,
    score_stats_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW-1:0] PtrMax = PtrW'(DEPTH - 1);
    localparam logic [3:0] DepthCnt = 4'(DEPTH);

    function automatic logic [9:0] bcd2bin(input logic [11:0] b);
        return 10'(b[11:8]) * 10'd100 + 10'(b[7:4]) * 10'd10 + 10'(b[3:0]);
    endfunction

    localparam logic [9:0] BestInitBin = bcd2bin(BEST_INIT);

    typedef enum logic [1:0] {StIdle, StLoad, StDiv, StB2b} state_e;

    state_e          state_q;
    logic [11:0]     score_q;
    logic [11:0]     last_q;
    logic [11:0]     best_q;
    logic [9:0]      best_bin_q;
    logic [11:0]     avg_q;
    logic [3:0]      rounds_q;
    logic            busy_q;
    logic            err_q;
    logic [12:0]     sum_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [9:0]      ring_q [DEPTH];
    logic [3:0]      cnt_q;
    logic [12:0]     div_q;
    logic [3:0]      rem_q;
    logic [21:0]     dd_q;

    logic        bcd_ok;
    logic [9:0]  score_bin;
    logic [9:0]  best_ref;
    logic        full;
    logic [12:0] sum_next;
    logic [4:0]  div_shift;
    logic        div_ge;
    logic [21:0] dd_adj;
    logic [21:0] dd_next;

    always_comb begin
        bcd_ok    = (bus.score_bcd[11:8] <= 4'd9) && (bus.score_bcd[7:4] <= 4'd9) &&
                    (bus.score_bcd[3:0] <= 4'd9);
        score_bin = bcd2bin(score_q);
        // A clear arriving with the load is applied before the new score is compared.
        best_ref  = bus.clear_best ? BestInitBin : best_bin_q;
        full      = (rounds_q == DepthCnt);
        sum_next  = sum_q - (full ? 13'(ring_q[wr_ptr_q]) : 13'd0) + 13'(score_bin);
        div_shift = {rem_q, div_q[12]};
        div_ge    = (div_shift >= {1'b0, rounds_q});
        dd_adj    = dd_q;
        for (int d = 0; d < 3; d++) begin
            if (dd_adj[10 + 4 * d +: 4] >= 4'd5) begin
                dd_adj[10 + 4 * d +: 4] = dd_adj[10 + 4 * d +: 4] + 4'd3;
            end
        end
        dd_next = {dd_adj[20:0], 1'b0};
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            score_q    <= 12'h000;
            last_q     <= 12'h000;
            best_q     <= BEST_INIT;
            best_bin_q <= BestInitBin;
            avg_q      <= 12'h000;
            rounds_q   <= 4'd0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            sum_q      <= 13'd0;
            wr_ptr_q   <= '0;
            cnt_q      <= 4'd0;
            div_q      <= 13'd0;
            rem_q      <= 4'd0;
            dd_q       <= 22'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= 10'd0;
            end
        end else begin
            if (bus.clear_best) begin
                best_q     <= BEST_INIT;
                best_bin_q <= BestInitBin;
            end
            if (bus.score_valid && state_q != StIdle) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.score_valid) begin
                        if (bcd_ok) begin
                            score_q <= bus.score_bcd;
                            state_q <= StLoad;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    last_q <= score_q;
                    if (score_bin < best_ref) begin
                        best_q     <= score_q;
                        best_bin_q <= score_bin;
                    end
                    sum_q            <= sum_next;
                    ring_q[wr_ptr_q] <= score_bin;
                    wr_ptr_q         <= (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
                    if (!full) begin
                        rounds_q <= rounds_q + 4'd1;
                    end
                    busy_q  <= 1'b1;
                    div_q   <= sum_next;
                    rem_q   <= 4'd0;
                    cnt_q   <= 4'd0;
                    state_q <= StDiv;
                end
                StDiv: begin
                    div_q <= {div_q[11:0], div_ge};
                    rem_q <= div_ge ? 4'(div_shift - {1'b0, rounds_q}) : div_shift[3:0];
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd12) begin
                        // Quotient never exceeds 999, so the low 10 bits hold it.
                        dd_q    <= {12'h000, div_q[8:0], div_ge};
                        cnt_q   <= 4'd0;
                        state_q <= StB2b;
                    end
                end
                StB2b: begin
                    dd_q  <= dd_next;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd9) begin
                        avg_q   <= dd_next[21:10];
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    always_comb begin
        unique case (bus.sel)
            2'd0: bus.disp_bcd = last_q;
            2'd1: bus.disp_bcd = best_q;
            2'd2: bus.disp_bcd = avg_q;
            2'd3: bus.disp_bcd = {8'h00, rounds_q};
        endcase
    end

    assign bus.last_bcd = last_q;
    assign bus.best_bcd = best_q;
    assign bus.avg_bcd  = avg_q;
    assign bus.rounds   = rounds_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_score_stats.sv
// Directed bench for score_stats: expected averages are queued when a score is driven
// and popped when busy falls.
module tb_score_stats;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [11:0] exp_q [$];

    score_stats_if bus_if ();

    score_stats #(
        .DEPTH    (4),
        .BEST_INIT(12'h999)
    ) dut (
        .board_clk(clk),
        .reset    (rst),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus_if.score_valid = 1'b0;
        bus_if.score_bcd   = 12'h000;
        bus_if.clear_best  = 1'b0;
        bus_if.sel         = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the caller half a cycle after the accepting edge.
    task automatic send(input logic [11:0] bcd, input logic clr);
        @(negedge clk);
        bus_if.score_valid = 1'b1;
        bus_if.score_bcd   = bcd;
        bus_if.clear_best  = clr;
        @(negedge clk);
        bus_if.score_valid = 1'b0;
        bus_if.clear_best  = 1'b0;
    endtask

    task automatic send_good(input logic [11:0] bcd, input logic [11:0] exp_avg);
        exp_q.push_back(exp_avg);
        send(bcd, 1'b0);
    endtask

    task automatic wait_done(input string tag, input int exp_len);
        int n;
        logic [11:0] e;
        n = 0;
        @(negedge clk);
        while (bus_if.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, n, exp_len);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_avg"}, bus_if.avg_bcd, e);
        end
    endtask

    task automatic check_disp(input string tag, input logic [1:0] s, input logic [11:0] exp);
        bus_if.sel = s;
        #1;
        check(tag, bus_if.disp_bcd, exp);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;

        // Reset state
        do_reset();
        #1;
        check("rst_best", bus_if.best_bcd, 12'h999);
        check("rst_last", bus_if.last_bcd, 12'h000);
        check("rst_avg", bus_if.avg_bcd, 12'h000);
        check("rst_rounds", bus_if.rounds, 4'd0);
        check("rst_busy", bus_if.busy, 1'b0);
        check("rst_err", bus_if.err, 1'b0);
        check_disp("rst_disp_best", 2'd1, 12'h999);

        // Two scores
        send_good(12'h250, 12'h250);
        wait_done("s250", 23);
        send_good(12'h300, 12'h275);
        wait_done("s300", 23);
        check("two_best", bus_if.best_bcd, 12'h250);
        check("two_last", bus_if.last_bcd, 12'h300);
        check("two_rounds", bus_if.rounds, 4'd2);
        check_disp("two_disp_avg", 2'd2, 12'h275);
        check_disp("two_disp_last", 2'd0, 12'h300);

        // Fill the ring, then overwrite the oldest entry
        do_reset();
        send_good(12'h100, 12'h100);
        wait_done("f100", 23);
        send_good(12'h200, 12'h150);
        wait_done("f200", 23);
        send_good(12'h300, 12'h200);
        wait_done("f300", 23);
        send_good(12'h401, 12'h250);
        wait_done("f401", 23);
        send_good(12'h999, 12'h475);
        wait_done("f999", 23);
        check("wrap_best", bus_if.best_bcd, 12'h100);
        check("wrap_rounds", bus_if.rounds, 4'd4);
        check("wrap_last", bus_if.last_bcd, 12'h999);
        check("wrap_err", bus_if.err, 1'b0);

        // Floor division
        do_reset();
        send_good(12'h100, 12'h100);
        wait_done("a100", 23);
        send_good(12'h100, 12'h100);
        wait_done("b100", 23);
        send_good(12'h101, 12'h100);
        wait_done("c101", 23);
        check_disp("floor_disp_rounds", 2'd3, 12'h003);

        // Invalid BCD, then a score dropped while busy
        do_reset();
        send(12'h1A5, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("bad_err", bus_if.err, 1'b1);
        check("bad_rounds", bus_if.rounds, 4'd0);
        check("bad_busy", bus_if.busy, 1'b0);
        check("bad_last", bus_if.last_bcd, 12'h000);
        send_good(12'h500, 12'h500);
        repeat (4) @(negedge clk);
        bus_if.score_valid = 1'b1;
        bus_if.score_bcd   = 12'h700;
        @(negedge clk);
        bus_if.score_valid = 1'b0;
        wait_done("drop", 18);
        check("drop_rounds", bus_if.rounds, 4'd1);
        check("drop_last", bus_if.last_bcd, 12'h500);
        check("drop_err", bus_if.err, 1'b1);

        // clear_best coinciding with an accepted score
        do_reset();
        send_good(12'h200, 12'h200);
        wait_done("cb200", 23);
        check("cb_best_before", bus_if.best_bcd, 12'h200);
        exp_q.push_back(12'h350);
        send(12'h500, 1'b1);
        wait_done("cb500", 23);
        check("cb_best_after", bus_if.best_bcd, 12'h500);

        // Reset mid-computation
        send(12'h600, 1'b0);
        repeat (9) @(negedge clk);
        check("mid_busy_before", bus_if.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_busy", bus_if.busy, 1'b0);
        check("mid_rounds", bus_if.rounds, 4'd0);
        check("mid_last", bus_if.last_bcd, 12'h000);
        check("mid_best", bus_if.best_bcd, 12'h999);
        check("mid_avg", bus_if.avg_bcd, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("post_avg", bus_if.avg_bcd, 12'h000);
        check("post_busy", bus_if.busy, 1'b0);
        check("post_rounds", bus_if.rounds, 4'd0);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/score_stats.md
# score_stats

Reaction-round statistics engine sitting directly downstream of the 3-digit BCD reaction counter and upstream of the 7-segment display mux. On each completed round it captures the BCD score and updates the best (lowest) score. It also keeps a ring buffer of the last DEPTH scores and computes their integer average. The result is returned in BCD, ready for the BCD-to-7-segment decoders.

## Interface
- DEPTH, 4, ring-buffer depth; legal values 2, 4, 8.
- BEST_INIT, 12'h999, BCD value loaded into best on reset and on clear_best.

- board_clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- score_valid  in  1  one-cycle pulse: round finished, score_bcd stable.
- score_bcd  in  12  {hundreds, tens, ones} BCD reaction time in ms.
- clear_best  in  1  one-cycle pulse: reload best with BEST_INIT.
- sel  in  2  display select: 0 last, 1 best, 2 average, 3 round count.
- disp_bcd  out  12  combinational mux of the selected value; sel=3 gives {8'h00, rounds}.
- last_bcd  out  12  most recently accepted score.
- best_bcd  out  12  lowest accepted score since reset/clear.
- avg_bcd  out  12  floor(sum of buffered scores / rounds).
- rounds  out  4  number of valid buffer entries, saturates at DEPTH.
- busy  out  1  average computation in progress.
- err  out  1  sticky: invalid BCD input or score dropped while busy.

## Operation
- States: IDLE, LOAD, DIV, B2B.
- IDLE: score_valid is accepted when score_bcd has every digit ≤ 9.
  - Any digit > 9: input ignored, err set, no state change.
- LOAD (1 cycle):
  - bin = 100·d2 + 10·d1 + d0 (10 bits, 0–999).
  - If rounds == DEPTH, subtract the entry at wr_ptr from sum; then add bin. sum is 13 bits (max 8·999 = 7992); no overflow possible.
  - Write bin to buf[wr_ptr]; wr_ptr increments modulo DEPTH.
  - rounds increments, saturating at DEPTH.
  - last_bcd ← score_bcd.
  - If bin < best_bin (strict), best_bcd/best_bin ← new score.
- DIV (13 cycles): restoring division, sum / rounds, 1 quotient bit per cycle, MSB first. Quotient is floor and always ≤ 999.
- B2B (10 cycles): double-dabble of the 10-bit quotient into 3 BCD digits. On the final cycle avg_bcd is loaded; next state is IDLE.
- score_valid while in LOAD/DIV/B2B: dropped, err set; the in-flight computation is unaffected.
- clear_best: best ← BEST_INIT in any state.
  - If it coincides with an accepted score, the clear applies first; the new score is then compared, so best = new score.
- avg_bcd and last_bcd keep their previous values until the update completes; they never show partial results.
- err clears only on reset.

## Timing
- Accepting edge = edge T, where score_valid is sampled high in IDLE.
- T+1: LOAD completes. last_bcd, best_bcd, rounds updated; busy = 1.
- T+2 … T+14: DIV.
- T+15 … T+24: B2B.
- Edge T+24: avg_bcd valid, busy = 0, state IDLE.
- A new score is accepted at the earliest on edge T+25.
- Total input-to-average latency is 24 cycles.
- disp_bcd follows sel and registers combinationally with zero latency.
- Reset values:
  - last_bcd = 0, avg_bcd = 0, rounds = 0, busy = 0, err = 0.
  - best_bcd = BEST_INIT, sum = 0, wr_ptr = 0, buffer = 0.
  - disp_bcd follows from sel.
- Reset asserted mid-computation: everything returns to reset values immediately; no partial average is ever published.

## Test plan
- Reset, then sample all outputs → best 999, last 000, avg 000, rounds 0, busy 0, err 0; sel=1 shows 999.
- Scores 250 then 300, each after busy drops → avg 275, best 250, last 300, rounds 2; busy high exactly T+1 through T+23.
- Scores 100, 200, 300, 401 → avg 250. Then 999, overwriting 100 → sum 1900, avg 475, best stays 100, rounds 4.
- Scores 100, 100, 101 → avg 100 (floor of 301/3). sel=3 shows 003.
- score_bcd 12'h1A5 → ignored, err 1, rounds unchanged. Second score_valid at T+5 during busy → dropped, err 1, avg from the first score only.
- best = 200, then clear_best coinciding with score 500 → best 500. Reset asserted at T+10 → all reset values; no avg update afterward.
